// File: rtl/instr_encoder_loader.sv
// RV32I instruction encoder and program loader: packs decoded fields into 32-bit words and
// streams them to consecutive instruction-memory addresses. Define INSTR_CHECKSUM_EN for a checksum output.
module instr_encoder_loader #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  count,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            fmt,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [31:0]           imm,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
`ifdef INSTR_CHECKSUM_EN
    ,
    output logic [31:0]           checksum
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] remaining;
    logic                 accept;
    logic                 complete;
    logic                 legal;
    logic                 misaligned;
    logic                 start_load;
    logic [31:0]          word;

    // A new bundle may only enter when the output register is free or empties this cycle.
    assign complete   = mem_we && mem_ready;
    assign in_ready   = (state == S_LOAD) && (remaining != '0) && (!mem_we || mem_ready);
    assign accept     = in_valid && in_ready;
    assign busy       = (state != S_IDLE);
    assign legal      = (fmt <= FMT_J);
    assign misaligned = ((fmt == FMT_B) || (fmt == FMT_J)) && imm[0];
    assign start_load = (state == S_IDLE) && start && (count != '0);

    always_comb begin
        word = '0;
        case (fmt)
            FMT_R:   word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I:   word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U:   word = {imm[31:12], rd, opcode};
            FMT_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: word = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            done <= 1'b1;
                        end else begin
                            remaining <= count;
                            state     <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        remaining <= remaining - CNT_WIDTH'(1);
                        if (remaining == CNT_WIDTH'(1)) begin
                            state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (!mem_we || mem_ready) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Reload takes priority over clearing so a completing write can be replaced in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
        end else begin
            if (start_load) begin
                mem_addr <= BASE_ADDR;
            end else if (complete) begin
                mem_addr <= mem_addr + ADDR_WIDTH'(4);
            end
            if (accept && legal) begin
                mem_we    <= 1'b1;
                mem_wdata <= word;
            end else if (complete) begin
                mem_we <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((state == S_IDLE) && start) begin
            err <= 1'b0;
        end else if (accept && (!legal || misaligned)) begin
            err <= 1'b1;
        end
    end

`ifdef INSTR_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if ((state == S_IDLE) && start) begin
            checksum <= '0;
        end else if (complete) begin
            checksum <= checksum ^ mem_wdata;
        end
    end
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed plan scenarios plus randomized loads
// checked against an arithmetic encoding model and a write scoreboard.
module tb_instr_encoder_loader;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] count;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    fmt;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [31:0]   imm;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready;
    logic          busy;
    logic          done;
    logic          err;
`ifdef INSTR_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int bad_seen = 0;
    int timeouts = 0;
    bit rand_ready = 1'b0;

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    int          got_cyc[$];
    logic [31:0] exp_data[$];

    instr_encoder_loader dut (
        .clk(clk), .rst(rst), .start(start), .count(count),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
        .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .busy(busy), .done(done), .err(err)
`ifdef INSTR_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference encoding built from field positions with shifts and masks.
    function automatic logic [31:0] encode_ref(input logic [2:0] f, input logic [6:0] op,
        input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] d,
        input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im);
        logic [31:0] base;
        base = 32'(op);
        case (f)
            3'd0: return base | (32'(f7) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7);
            3'd1: return base | ((im & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | (32'(d) << 7);
            3'd2: return base | (((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | ((im & 32'h1F) << 7);
            3'd3: return base | (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(s2) << 20) | (32'(s1) << 15)
                          | (32'(f3) << 12) | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
            3'd4: return base | (im & 32'hFFFFF000) | (32'(d) << 7);
            3'd5: return base | (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21) | (((im >> 11) & 32'h1) << 20)
                          | (((im >> 12) & 32'hFF) << 12) | (32'(d) << 7);
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we && mem_ready) begin
                got_addr.push_back(mem_addr);
                got_data.push_back(mem_wdata);
                got_cyc.push_back(cyc);
            end
            if (done) done_cnt++;
            if (in_valid && in_ready) begin
                if (fmt > 3'd5) begin
                    bad_seen++;
                end else begin
                    exp_data.push_back(encode_ref(fmt, opcode, funct3, funct7, rd, rs1, rs2, imm));
                    if ((fmt == 3'd3 || fmt == 3'd5) && imm[0]) bad_seen++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) mem_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic do_start(input int c);
        start = 1'b1;
        count = CW'(c);
        tick();
        start = 1'b0;
    endtask

    task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
        input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
        input logic [31:0] im);
        fmt = f; opcode = op; funct3 = f3; funct7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    endtask

    task automatic rand_fields(input bit legal_only);
        int r = $urandom_range(0, 15);
        if (legal_only) fmt = 3'($urandom_range(0, 5));
        else fmt = (r < 13) ? 3'(r % 6) : 3'(6 + (r % 2));
        opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); imm = $urandom;
    endtask

    task automatic send();
        int  n = 0;
        bit  acc = 1'b0;
        in_valid = 1'b1;
        while (!acc && n < 64) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!acc) timeouts++;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (done === 1'b1) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; count = '0; in_valid = 1'b0; mem_ready = 1'b1;
        set_fields(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b want 0", in_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we: got %0b want 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %0b want 0", err); end
`ifdef INSTR_CHECKSUM_EN
        checks++; if (checksum !== 32'h0) begin errors++; $display("[TB] FAIL reset_checksum: got %h want 0", checksum); end
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        int gb = got_data.size();
        int db = done_cnt;
        do_start(1);
        set_fields(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        send();
        checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL single_we: got %0b want 1", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL single_addr: got %h want 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h00500093) begin errors++; $display("[TB] FAIL single_data: got %h want 00500093", mem_wdata); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy: got %0b want 1", busy); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL single_done: got %0b want 1", done); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL single_we_clear: got %0b want 0", mem_we); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL single_done_pulse: got %0b want 0", done); end
        checks++; if (got_data.size() - gb != 1) begin errors++; $display("[TB] FAIL single_nwrites: got %0d want 1", got_data.size() - gb); end
        checks++; if (done_cnt - db != 1) begin errors++; $display("[TB] FAIL single_ndone: got %0d want 1", done_cnt - db); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want[3];
        int gb = got_data.size();
        bit ok;
        want[0] = 32'h0080A103; want[1] = 32'hFE208EE3; want[2] = 32'h123452B7;
        do_start(3);
        set_fields(3'd1, 7'h03, 3'd2, 7'd0, 5'd2, 5'd1, 5'd0, 32'd8);
        send();
        set_fields(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
        send();
        set_fields(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000);
        send();
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_done_timeout: got no done want done"); end
        tick();
        checks++; if (got_data.size() - gb != 3) begin errors++; $display("[TB] FAIL b2b_nwrites: got %0d want 3", got_data.size() - gb); end
        for (int i = 0; i < 3 && gb + i < got_data.size(); i++) begin
            checks++; if (got_addr[gb+i] !== 32'(4 * i)) begin errors++; $display("[TB] FAIL b2b_addr%0d: got %h want %h", i, got_addr[gb+i], 4 * i); end
            checks++; if (got_data[gb+i] !== want[i]) begin errors++; $display("[TB] FAIL b2b_data%0d: got %h want %h", i, got_data[gb+i], want[i]); end
            if (i > 0) begin
                checks++; if (got_cyc[gb+i] != got_cyc[gb+i-1] + 1) begin errors++; $display("[TB] FAIL b2b_cycle%0d: got %0d want %0d", i, got_cyc[gb+i], got_cyc[gb+i-1] + 1); end
            end
        end
`ifdef INSTR_CHECKSUM_EN
        checks++; if (checksum !== (want[0] ^ want[1] ^ want[2])) begin errors++; $display("[TB] FAIL b2b_checksum: got %h want %h", checksum, want[0] ^ want[1] ^ want[2]); end
`endif
    endtask

    task automatic test_backpressure();
        int gb = got_data.size();
        int eb = exp_data.size();
        int db = done_cnt;
        int t0 = timeouts;
        logic [31:0] snap_a;
        logic [31:0] snap_d;
        bit ok;
        do_start(4);
        rand_fields(1'b1); send();
        rand_fields(1'b1); send();
        mem_ready = 1'b0;
        snap_a = mem_addr;
        snap_d = mem_wdata;
        checks++; if (snap_a !== 32'h4) begin errors++; $display("[TB] FAIL bp_stall_addr: got %h want 4", snap_a); end
        rand_fields(1'b1);
        in_valid = 1'b1;
        start = 1'b1;
        count = CW'(5);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL bp_we%0d: got %0b want 1", i, mem_we); end
            checks++; if (mem_addr !== snap_a) begin errors++; $display("[TB] FAIL bp_addr%0d: got %h want %h", i, mem_addr, snap_a); end
            checks++; if (mem_wdata !== snap_d) begin errors++; $display("[TB] FAIL bp_data%0d: got %h want %h", i, mem_wdata, snap_d); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready%0d: got %0b want 0", i, in_ready); end
        end
        start = 1'b0;
        mem_ready = 1'b1;
        send();
        rand_fields(1'b1); send();
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_done_timeout: got no done want done"); end
        tick();
        checks++; if (got_data.size() - gb != 4) begin errors++; $display("[TB] FAIL bp_nwrites: got %0d want 4", got_data.size() - gb); end
        for (int i = 0; i < 4 && gb + i < got_data.size() && eb + i < exp_data.size(); i++) begin
            checks++; if (got_addr[gb+i] !== 32'(4 * i)) begin errors++; $display("[TB] FAIL bp_waddr%0d: got %h want %h", i, got_addr[gb+i], 4 * i); end
            checks++; if (got_data[gb+i] !== exp_data[eb+i]) begin errors++; $display("[TB] FAIL bp_wdata%0d: got %h want %h", i, got_data[gb+i], exp_data[eb+i]); end
        end
        checks++; if (done_cnt - db != 1) begin errors++; $display("[TB] FAIL bp_ndone: got %0d want 1", done_cnt - db); end
        checks++; if (timeouts != t0) begin errors++; $display("[TB] FAIL bp_accept_timeout: got %0d want %0d", timeouts, t0); end
    endtask

    task automatic test_count_zero();
        int gb = got_data.size();
        int db = done_cnt;
        do_start(0);
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL zero_done: got %0b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL zero_busy: got %0b want 0", busy); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                errors++; $display("[TB] FAIL zero_idle%0d: got we=%0b busy=%0b done=%0b want 0 0 0", i, mem_we, busy, done);
            end
        end
        checks++; if (got_data.size() != gb) begin errors++; $display("[TB] FAIL zero_nwrites: got %0d want 0", got_data.size() - gb); end
        checks++; if (done_cnt - db != 1) begin errors++; $display("[TB] FAIL zero_ndone: got %0d want 1", done_cnt - db); end
    endtask

    task automatic test_illegal();
        int gb = got_data.size();
        int db = done_cnt;
        bit ok;
        do_start(2);
        set_fields(3'd7, 7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
        send();
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL illegal_err: got %0b want 1", err); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL illegal_we: got %0b want 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL illegal_addr: got %h want 0", mem_addr); end
        set_fields(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
        send();
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL illegal_done_timeout: got no done want done"); end
        tick();
        checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL illegal_err_sticky: got %0b want 1", err); end
        checks++; if (got_data.size() - gb != 1) begin errors++; $display("[TB] FAIL illegal_nwrites: got %0d want 1", got_data.size() - gb); end
        if (got_data.size() > gb) begin
            checks++; if (got_addr[gb] !== 32'h0) begin errors++; $display("[TB] FAIL illegal_waddr: got %h want 0", got_addr[gb]); end
            checks++; if (got_data[gb] !== 32'h00500093) begin errors++; $display("[TB] FAIL illegal_wdata: got %h want 00500093", got_data[gb]); end
        end
        checks++; if (done_cnt - db != 1) begin errors++; $display("[TB] FAIL illegal_ndone: got %0d want 1", done_cnt - db); end
        do_start(1);
        checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL illegal_err_clear: got %0b want 0", err); end
        send();
        wait_done(ok);
        tick();
    endtask

    task automatic test_reset_mid();
        int gb = got_data.size();
        int db = done_cnt;
        do_start(2);
        set_fields(3'd1, 7'b0010011, 3'd0, 7'd0, 5'd3, 5'd4, 5'd0, 32'd77);
        send();
        mem_ready = 1'b0;
        tick();
        checks++; if (mem_we !== 1'b1) begin errors++; $display("[TB] FAIL rmid_pending: got %0b want 1", mem_we); end
        rst = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL rmid_we: got %0b want 0", mem_we); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL rmid_addr_data: got %h %h want 0 0", mem_addr, mem_wdata); end
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy_ready: got %0b %0b want 0 0", busy, in_ready); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("[TB] FAIL rmid_done_err: got %0b %0b want 0 0", done, err); end
`ifdef INSTR_CHECKSUM_EN
        checks++; if (checksum !== 32'h0) begin errors++; $display("[TB] FAIL rmid_checksum: got %h want 0", checksum); end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_ready = 1'b1;
        repeat (4) tick();
        checks++; if (done_cnt != db) begin errors++; $display("[TB] FAIL rmid_no_done: got %0d want 0", done_cnt - db); end
        checks++; if (got_data.size() != gb) begin errors++; $display("[TB] FAIL rmid_no_write: got %0d want 0", got_data.size() - gb); end
    endtask

    task automatic test_random();
        bit ok;
        rand_ready = 1'b1;
        for (int l = 0; l < 10; l++) begin
            int n  = $urandom_range(1, 6);
            int gb = got_data.size();
            int eb = exp_data.size();
            int db = done_cnt;
            int bb = bad_seen;
            int t0 = timeouts;
            int nexp;
            logic [31:0] csum;
            do_start(n);
            for (int k = 0; k < n; k++) begin
                rand_fields(1'b0);
                repeat ($urandom_range(0, 2)) tick();
                send();
            end
            wait_done(ok);
            checks++; if (!ok) begin errors++; $display("[TB] FAIL rand%0d_done_timeout: got no done want done", l); end
            tick();
            nexp = exp_data.size() - eb;
            csum = 32'h0;
            checks++; if (got_data.size() - gb != nexp) begin errors++; $display("[TB] FAIL rand%0d_nwrites: got %0d want %0d", l, got_data.size() - gb, nexp); end
            for (int i = 0; i < nexp && gb + i < got_data.size(); i++) begin
                csum = csum ^ exp_data[eb+i];
                checks++; if (got_addr[gb+i] !== 32'(4 * i)) begin errors++; $display("[TB] FAIL rand%0d_addr%0d: got %h want %h", l, i, got_addr[gb+i], 4 * i); end
                checks++; if (got_data[gb+i] !== exp_data[eb+i]) begin errors++; $display("[TB] FAIL rand%0d_data%0d: got %h want %h", l, i, got_data[gb+i], exp_data[eb+i]); end
            end
            checks++; if (err !== (bad_seen > bb)) begin errors++; $display("[TB] FAIL rand%0d_err: got %0b want %0b", l, err, bad_seen > bb); end
            checks++; if (done_cnt - db != 1) begin errors++; $display("[TB] FAIL rand%0d_ndone: got %0d want 1", l, done_cnt - db); end
            checks++; if (timeouts != t0) begin errors++; $display("[TB] FAIL rand%0d_accept_timeout: got %0d want %0d", l, timeouts, t0); end
`ifdef INSTR_CHECKSUM_EN
            checks++; if (checksum !== csum) begin errors++; $display("[TB] FAIL rand%0d_checksum: got %h want %h", l, checksum, csum); end
`endif
        end
        rand_ready = 1'b0;
        mem_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_count_zero();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Sequential RV32I instruction encoder and program loader, the write side of the datapath's instruction decode.
- Accepts decoded instruction fields over a valid/ready stream.
- Packs each into a 32-bit RV32I word (R/I/S/B/U/J formats).
- Writes words to consecutive instruction-memory addresses through a backpressured write port.
- Used at boot and by benches to load programs that the control unit later decodes.

Parameters:
ADDR_WIDTH, 32, width of mem_addr
BASE_ADDR, 32'h0000_0000, address of first word written after start
CNT_WIDTH, 16, width of count and internal remaining counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a load; sampled only in IDLE
count  in  CNT_WIDTH  number of instructions to load; sampled with start
in_valid  in  1  field bundle valid
in_ready  out  1  field bundle accepted when in_valid && in_ready
fmt  in  3  0=R 1=I 2=S 3=B 4=U 5=J, 6/7 illegal
opcode  in  7  instr[6:0]
funct3  in  3  instr[14:12] (R/I/S/B)
funct7  in  7  instr[31:25] (R only)
rd  in  5  destination register (R/I/U/J)
rs1  in  5  source 1 (R/I/S/B)
rs2  in  5  source 2 (R/S/B)
imm  in  32  sign-extended immediate; bits used depend on fmt
mem_we  out  1  write request, held until mem_ready
mem_addr  out  ADDR_WIDTH  byte address of word
mem_wdata  out  32  encoded instruction
mem_ready  in  1  memory accepts write when mem_we && mem_ready
busy  out  1  high in LOAD and FLUSH
done  out  1  one-cycle pulse when the last write completes
err  out  1  sticky; set on illegal fmt or misaligned B/J imm; cleared by start or rst

Behaviour:
- Reset values: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, err=0, state=IDLE, remaining=0.
- Reset mid-operation aborts immediately. A pending write is dropped and no done pulse is issued.
- FSM states:
  - IDLE: start with count=0 pulses done next cycle and stays in IDLE. start with count>0 loads remaining=count, sets mem_addr=BASE_ADDR, clears err, goes to LOAD.
  - LOAD: in_ready = (remaining>0) && (!mem_we || mem_ready). Each accept decrements remaining. When remaining reaches 0, go to FLUSH.
  - FLUSH: wait for the final write to complete (mem_we && mem_ready, or no pending write), then pulse done and return to IDLE.
  - start is ignored outside IDLE.
- Latency: a bundle accepted in cycle N appears as mem_we/mem_addr/mem_wdata in cycle N+1.
  - The output register reloads in the same cycle the previous write completes, giving full throughput of 1 word/cycle when mem_ready=1.
- Backpressure: while mem_we && !mem_ready, mem_addr and mem_wdata stay stable and in_ready=0.
- mem_addr advances by 4 after each completed write and wraps modulo 2^ADDR_WIDTH.
- Encoding (unused fields ignored):
  - R: {funct7,rs2,rs1,funct3,rd,opcode}
  - I: {imm[11:0],rs1,funct3,rd,opcode}
  - S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
  - B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
  - U: {imm[31:12],rd,opcode}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
- Illegal fmt (6/7): bundle is consumed and counts toward remaining. err is set, no write is issued, and mem_addr is unchanged.
- B/J with imm[0]=1: err is set. The word is still written; imm[0] is dropped by construction.

Optional Feature:
INSTR_CHECKSUM_EN
- Defined: adds output port checksum [31:0]. It resets to 0, clears on accepted start, and XOR-accumulates each mem_wdata on write completion. Final value is valid when done pulses.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. start,count=1; I fmt, opcode 7'b0010011, funct3 0, rd 1, rs1 0, imm 5, mem_ready=1 -> one cycle later mem_we=1, mem_addr=0x0, mem_wdata=0x00500093; done pulses one cycle after the write completes.
2. count=3, back-to-back: lw x2,8(x1) (I, op 0x03, f3 2), beq x1,x2,-4 (B, op 0x63, f3 0), lui x5,0x12345000 (U, op 0x37) -> writes 0x0080A103@0x0, 0xFE208EE3@0x4, 0x123452B7@0x8 on 3 consecutive cycles.
3. mem_ready held low 3 cycles mid-stream -> mem_we/addr/data stable, in_ready=0 throughout; resumes with no lost or duplicated word.
4. count=0 start -> done pulses next cycle, mem_we never asserts, busy stays 0.
5. count=2, first bundle fmt=7, second addi -> err=1, single write of the addi at address 0x0, done after it; next start clears err.
6. rst asserted while mem_we=1 with mem_ready=0 -> all outputs at reset values the same cycle, no done pulse; with INSTR_CHECKSUM_EN, test 2 gives checksum = 0x0080A103 ^ 0xFE208EE3 ^ 0x123452B7.
